// File: rtl/adpll_loop_filter.sv
// adpll_loop_filter: proportional-integral loop filter for the ADPLL.
// Once per synchronised reference edge it waits for the phase detector to
// settle, samples the signed phase error and produces an unsigned DCO control
// word, plus lock and saturation status.
//
// Output handshake: ctrl_valid_o is a one-cycle strobe with no back-pressure.
// ctrl_word_o, locked_o and saturated_o change only in the cycle where
// ctrl_valid_o is high, and they hold their value until the next strobe.
module adpll_loop_filter #(
  parameter int PD_WIDTH      = 5,
  parameter int CTRL_WIDTH    = 10,
  parameter int KP_SHIFT      = 2,
  parameter int KI_SHIFT      = 3,
  parameter int SETTLE_CYCLES = 4,
  parameter int LOCK_THRESH   = 1,
  parameter int LOCK_COUNT    = 16
) (
  input  logic                                 fpga_clk_i,
  input  logic                                 reset_n_i,
  input  logic                                 enable_i,
  input  logic                                 reference_i,
  input  logic signed [PD_WIDTH-1:0]           pd_clock_cycles_i,
  output logic [CTRL_WIDTH-1:0]                ctrl_word_o,
  output logic                                 ctrl_valid_o,
  output logic                                 locked_o,
  output logic                                 saturated_o,
  output logic [2:0]                           debug_state_o,
  output logic signed [CTRL_WIDTH+KI_SHIFT-1:0] debug_acc_o
);

  // Integrator width gives KI_SHIFT fractional bits below the control LSB.
  localparam int INT_WIDTH = CTRL_WIDTH + KI_SHIFT;
  // The control sum is formed at full integrator precision plus two guard
  // bits, so it is exact for every reachable operand and the clamp below
  // only has to inspect the sign bit and the bits above CTRL_WIDTH.
  localparam int SUM_WIDTH = INT_WIDTH + 2;
  localparam int SCW       = $clog2(SETTLE_CYCLES + 1);
  localparam int LCW       = $clog2(LOCK_COUNT + 1);

  localparam logic [SUM_WIDTH-1:0]  CENTRE      = SUM_WIDTH'(1) << (CTRL_WIDTH - 1);
  localparam logic [CTRL_WIDTH-1:0] CTRL_RESET  = CTRL_WIDTH'(1) << (CTRL_WIDTH - 1);
  localparam logic [CTRL_WIDTH-1:0] CTRL_MAX    = {CTRL_WIDTH{1'b1}};
  localparam logic [INT_WIDTH-1:0]  ACC_MAX     = {1'b0, {(INT_WIDTH-1){1'b1}}};
  localparam logic [INT_WIDTH-1:0]  ACC_MIN     = {1'b1, {(INT_WIDTH-1){1'b0}}};
  localparam logic [SCW-1:0]        SETTLE_LOAD = SCW'(SETTLE_CYCLES);
  localparam logic [SCW-1:0]        SETTLE_LAST = SCW'(1);
  localparam logic [LCW-1:0]        LOCK_MAX    = LCW'(LOCK_COUNT);
  localparam logic [PD_WIDTH:0]     LOCK_LIMIT  = (PD_WIDTH + 1)'(LOCK_THRESH);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_EDGE = 3'd1,
    S_SETTLE    = 3'd2,
    S_SAMPLE    = 3'd3,
    S_UPDATE    = 3'd4
  } state_t;

  state_t                       state;
  logic [SCW-1:0]               settle_cnt;
  logic [LCW-1:0]               lock_cnt;
  logic signed [INT_WIDTH-1:0]  acc;

  logic                         ref_meta;
  logic                         ref_sync;
  logic                         ref_prev;
  logic                         rise;

  logic [INT_WIDTH:0]           acc_wide;
  logic signed [INT_WIDTH-1:0]  acc_next;
  logic signed [INT_WIDTH-1:0]  integ;
  logic [SUM_WIDTH-1:0]         prop;
  logic [SUM_WIDTH-1:0]         integ_ext;
  logic [SUM_WIDTH-1:0]         sum;
  logic [CTRL_WIDTH-1:0]        ctrl_next;
  logic                         sat_next;
  logic [PD_WIDTH:0]            err_ext;
  logic [PD_WIDTH:0]            err_abs;
  logic                         in_lock;
  logic [LCW-1:0]               lock_cnt_next;

  assign rise          = ref_sync & ~ref_prev;
  assign debug_state_o = state;
  assign debug_acc_o   = acc;

  // Two-flop synchroniser for the asynchronous reference, then an edge flop.
  always_ff @(posedge fpga_clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      ref_meta <= 1'b0;
      ref_sync <= 1'b0;
      ref_prev <= 1'b0;
    end else begin
      ref_meta <= reference_i;
      ref_sync <= ref_meta;
      ref_prev <= ref_sync;
    end
  end

  // Update datapath: saturating integrator, P and I terms, clamp, lock count.
  // It is evaluated on the word being sampled so the results can be
  // registered at the SAMPLE edge and appear together with the valid strobe.
  always_comb begin
    acc_wide = {acc[INT_WIDTH-1], acc}
             + {{(INT_WIDTH + 1 - PD_WIDTH){pd_clock_cycles_i[PD_WIDTH-1]}}, pd_clock_cycles_i};
    if (acc_wide[INT_WIDTH] != acc_wide[INT_WIDTH-1]) begin
      acc_next = acc_wide[INT_WIDTH] ? ACC_MIN : ACC_MAX;
    end else begin
      acc_next = acc_wide[INT_WIDTH-1:0];
    end

    prop = {{(SUM_WIDTH - PD_WIDTH){pd_clock_cycles_i[PD_WIDTH-1]}}, pd_clock_cycles_i}
           << KP_SHIFT;
    integ     = acc_next >>> KI_SHIFT;
    integ_ext = {{2{integ[INT_WIDTH-1]}}, integ};
    sum       = CENTRE + prop + integ_ext;

    ctrl_next = sum[CTRL_WIDTH-1:0];
    sat_next  = 1'b0;
    if (sum[SUM_WIDTH-1]) begin
      ctrl_next = '0;
      sat_next  = 1'b1;
    end else if (|sum[SUM_WIDTH-2:CTRL_WIDTH]) begin
      ctrl_next = CTRL_MAX;
      sat_next  = 1'b1;
    end

    // One extra bit so the most negative error has a representable magnitude.
    err_ext = {pd_clock_cycles_i[PD_WIDTH-1], pd_clock_cycles_i};
    err_abs = err_ext[PD_WIDTH] ? (~err_ext + 1'b1) : err_ext;
    in_lock = (err_abs <= LOCK_LIMIT);

    lock_cnt_next = '0;
    if (in_lock) begin
      lock_cnt_next = (lock_cnt == LOCK_MAX) ? lock_cnt : lock_cnt + 1'b1;
    end
  end

  // Sample sequencer and all filter state; disable returns everything to reset.
  always_ff @(posedge fpga_clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state        <= S_IDLE;
      settle_cnt   <= '0;
      lock_cnt     <= '0;
      acc          <= '0;
      ctrl_word_o  <= CTRL_RESET;
      ctrl_valid_o <= 1'b0;
      locked_o     <= 1'b0;
      saturated_o  <= 1'b0;
    end else if (!enable_i) begin
      state        <= S_IDLE;
      settle_cnt   <= '0;
      lock_cnt     <= '0;
      acc          <= '0;
      ctrl_word_o  <= CTRL_RESET;
      ctrl_valid_o <= 1'b0;
      locked_o     <= 1'b0;
      saturated_o  <= 1'b0;
    end else begin
      ctrl_valid_o <= 1'b0;
      case (state)
        S_IDLE: begin
          state <= S_WAIT_EDGE;
        end
        S_WAIT_EDGE: begin
          if (rise) begin
            state      <= S_SETTLE;
            settle_cnt <= SETTLE_LOAD;
          end
        end
        S_SETTLE: begin
          // Edges arriving here are simply not looked at, hence dropped.
          if (settle_cnt == SETTLE_LAST) begin
            state <= S_SAMPLE;
          end else begin
            settle_cnt <= settle_cnt - 1'b1;
          end
        end
        S_SAMPLE: begin
          acc          <= acc_next;
          ctrl_word_o  <= ctrl_next;
          saturated_o  <= sat_next;
          lock_cnt     <= lock_cnt_next;
          locked_o     <= (lock_cnt_next == LOCK_MAX);
          ctrl_valid_o <= 1'b1;
          state        <= S_UPDATE;
        end
        S_UPDATE: begin
          state <= S_WAIT_EDGE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adpll_loop_filter.sv
// Testbench for adpll_loop_filter: hand-computed vector table, a behavioural
// reference model for randomized and long-run sequences, and directed
// sequences for the disable, double-edge and asynchronous reset corners.
module tb_adpll_loop_filter;

  localparam int PD_W   = 5;
  localparam int CW     = 10;
  localparam int KP     = 2;
  localparam int KI     = 3;
  localparam int SETTLE = 4;
  localparam int LTH    = 1;
  localparam int LCNT   = 16;
  localparam int INT_W  = CW + KI;
  // Reference driven at a negedge -> strobe seen at this many negedges later.
  localparam int LAT    = SETTLE + 4;

  // ---------------- clock / reset ----------------
  logic                    clk;
  logic                    reset_n;
  logic                    enable;
  logic                    reference;
  logic signed [PD_W-1:0]  pd;
  logic [CW-1:0]           ctrl_word;
  logic                    ctrl_valid;
  logic                    locked;
  logic                    saturated;
  logic [2:0]              dbg_state;
  logic signed [INT_W-1:0] dbg_acc;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  adpll_loop_filter #(
    .PD_WIDTH(PD_W), .CTRL_WIDTH(CW), .KP_SHIFT(KP), .KI_SHIFT(KI),
    .SETTLE_CYCLES(SETTLE), .LOCK_THRESH(LTH), .LOCK_COUNT(LCNT)
  ) dut (
    .fpga_clk_i(clk),
    .reset_n_i(reset_n),
    .enable_i(enable),
    .reference_i(reference),
    .pd_clock_cycles_i(pd),
    .ctrl_word_o(ctrl_word),
    .ctrl_valid_o(ctrl_valid),
    .locked_o(locked),
    .saturated_o(saturated),
    .debug_state_o(dbg_state),
    .debug_acc_o(dbg_acc)
  );

  // ---------------- scoreboard ----------------
  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Plain integer arithmetic straight from the filter equations.
  int m_acc, m_lock, m_ctrl, m_sat, m_locked;

  task automatic model_reset();
    m_acc = 0; m_lock = 0; m_ctrl = 1 << (CW - 1); m_sat = 0; m_locked = 0;
  endtask

  task automatic model_step(input int err);
    int lo, hi, d, integ, raw, mag;
    lo = -(1 << (INT_W - 1));
    hi = (1 << (INT_W - 1)) - 1;
    d  = 1 << KI;
    m_acc = m_acc + err;
    if (m_acc > hi) m_acc = hi;
    if (m_acc < lo) m_acc = lo;
    // floor(m_acc / 2^KI)
    if (m_acc >= 0) integ = m_acc / d;
    else            integ = -((-m_acc + d - 1) / d);
    raw = (1 << (CW - 1)) + err * (1 << KP) + integ;
    m_sat = 0;
    if (raw < 0) begin
      m_ctrl = 0; m_sat = 1;
    end else if (raw > (1 << CW) - 1) begin
      m_ctrl = (1 << CW) - 1; m_sat = 1;
    end else begin
      m_ctrl = raw;
    end
    mag = (err < 0) ? -err : err;
    if (mag <= LTH) m_lock = (m_lock < LCNT) ? m_lock + 1 : LCNT;
    else            m_lock = 0;
    m_locked = (m_lock == LCNT) ? 1 : 0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0; enable = 1'b0; reference = 1'b0; pd = '0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    model_reset();
  endtask

  task automatic compare_model();
    check("ctrl_word", int'(ctrl_word), m_ctrl);
    check("saturated", int'(saturated), m_sat);
    check("locked", int'(locked), m_locked);
    check("acc", int'(dbg_acc), m_acc);
  endtask

  // One reference edge carrying err; waits (bounded) for the strobe.
  task automatic send_edge(input int err, output int lat, output bit got);
    @(negedge clk);
    pd = err[PD_W-1:0];
    reference = 1'b1;
    got = 1'b0;
    lat = 0;
    for (int i = 1; i <= 40 && !got; i++) begin
      @(negedge clk);
      if (ctrl_valid) begin
        got = 1'b1;
        lat = i;
      end
    end
    if (!got) begin
      check("valid_timeout", 0, 1);
    end else begin
      model_step(err);
      check("latency", lat, LAT);
      compare_model();
      @(negedge clk);
      check("valid_width", int'(ctrl_valid), 0);
    end
    reference = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit do_reset;
    int err;
    int ctrl;
    int acc;
    int sat;
  } vec_t;

  vec_t tab[5];

  initial begin
    int lat, prev, pulses, first_lat, err;
    bit got;

    tab[0] = '{1'b1,   3, 524,   3, 0};
    tab[1] = '{1'b0,   3, 524,   6, 0};
    tab[2] = '{1'b1, -16, 446, -16, 0};
    tab[3] = '{1'b0, -16, 444, -32, 0};
    tab[4] = '{1'b0,  15, 569, -17, 0};

    reset_n = 1'b0; enable = 1'b0; reference = 1'b0; pd = '0;
    do_reset();

    // Reset values.
    check("rst_ctrl", int'(ctrl_word), 512);
    check("rst_valid", int'(ctrl_valid), 0);
    check("rst_locked", int'(locked), 0);
    check("rst_sat", int'(saturated), 0);
    check("rst_acc", int'(dbg_acc), 0);
    check("rst_state", int'(dbg_state), 0);

    // Enabled with no reference edges: nothing moves.
    enable = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      check("idle_valid", int'(ctrl_valid), 0);
      check("idle_ctrl", int'(ctrl_word), 512);
    end
    check("idle_locked", int'(locked), 0);
    check("idle_sat", int'(saturated), 0);

    // Table-driven single updates.
    for (int v = 0; v < 5; v++) begin
      if (tab[v].do_reset) begin
        do_reset();
        enable = 1'b1;
      end
      send_edge(tab[v].err, lat, got);
      check("tab_ctrl", int'(ctrl_word), tab[v].ctrl);
      check("tab_acc", int'(dbg_acc), tab[v].acc);
      check("tab_sat", int'(saturated), tab[v].sat);
    end

    // Long positive run: monotonic, clamps, integrator pins at its maximum.
    do_reset();
    enable = 1'b1;
    prev = 512;
    for (int n = 1; n <= 300; n++) begin
      send_edge(15, lat, got);
      check("monotonic", int'(int'(ctrl_word) >= prev), 1);
      if (n == 241) begin
        check("run241_ctrl", int'(ctrl_word), 1023);
        check("run241_sat", int'(saturated), 0);
      end
      if (n == 242) begin
        check("run242_ctrl", int'(ctrl_word), 1023);
        check("run242_sat", int'(saturated), 1);
      end
      prev = int'(ctrl_word);
    end
    check("run_acc_max", int'(dbg_acc), 4095);

    // Drop enable in SETTLE: no strobe, reset values on the next edge.
    @(negedge clk);
    pd = 5'sd7;
    reference = 1'b1;
    repeat (4) @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    check("dis_ctrl", int'(ctrl_word), 512);
    check("dis_sat", int'(saturated), 0);
    check("dis_locked", int'(locked), 0);
    check("dis_acc", int'(dbg_acc), 0);
    check("dis_state", int'(dbg_state), 0);
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i == 5) enable = 1'b1;
      if (ctrl_valid) pulses++;
    end
    check("dis_pulses", pulses, 0);
    reference = 1'b0;
    repeat (3) @(negedge clk);
    model_reset();

    // Lock acquisition, loss, and no early re-lock.
    do_reset();
    enable = 1'b1;
    for (int i = 0; i < 16; i++) begin
      send_edge(int'($urandom_range(0, 2)) - 1, lat, got);
      check("lock_acq", int'(locked), (i == 15) ? 1 : 0);
    end
    send_edge(2, lat, got);
    check("lock_lost", int'(locked), 0);
    for (int i = 0; i < 15; i++) begin
      send_edge(int'($urandom_range(0, 2)) - 1, lat, got);
      check("lock_relock", int'(locked), 0);
    end

    // Randomized errors against the model.
    do_reset();
    enable = 1'b1;
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 2) == 0) err = int'($urandom_range(0, 2)) - 1;
      else                           err = int'($urandom_range(0, 31)) - 16;
      send_edge(err, lat, got);
    end

    // Second reference edge during SETTLE is ignored.
    @(negedge clk);
    pd = 5'sd5;
    reference = 1'b1;
    repeat (2) @(negedge clk);
    reference = 1'b0;
    @(negedge clk);
    reference = 1'b1;
    pulses = 0;
    first_lat = 0;
    for (int i = 4; i < 34; i++) begin
      @(negedge clk);
      if (ctrl_valid) begin
        pulses++;
        if (first_lat == 0) first_lat = i;
      end
    end
    check("dbl_pulses", pulses, 1);
    check("dbl_latency", first_lat, LAT);
    model_step(5);
    compare_model();
    reference = 1'b0;
    repeat (3) @(negedge clk);

    // Asynchronous reset while the strobe is high.
    @(negedge clk);
    pd = 5'sd9;
    reference = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (ctrl_valid) got = 1'b1;
    end
    check("arst_seen_valid", int'(got), 1);
    model_step(9);
    check("arst_pre_ctrl", int'(ctrl_word), m_ctrl);
    #1 reset_n = 1'b0;
    #1;
    check("arst_ctrl", int'(ctrl_word), 512);
    check("arst_valid", int'(ctrl_valid), 0);
    check("arst_acc", int'(dbg_acc), 0);
    check("arst_locked", int'(locked), 0);
    check("arst_sat", int'(saturated), 0);
    check("arst_state", int'(dbg_state), 0);
    @(negedge clk);
    reference = 1'b0;
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
